// File: rtl/transition_pkg.sv
// transition_pkg: shared state encoding, widths and blank code for the transition sequencer
package transition_pkg;
   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;
   localparam int FRAME_W = 3;
   localparam int TICK_W  = 8;
   localparam int PASS_W  = 4;
   localparam logic [FRAME_W-1:0] CTRL_BLANK = 3'b111;
endpackage

// File: rtl/sc_transition_frame_timer.sv
// sc_transition_frame_timer: counts tick pulses within one frame and strobes when the frame's last tick arrives
module sc_transition_frame_timer
   import transition_pkg::*;
#(
   parameter int FRAME_TICKS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tick_in,
   output logic frame_expire
);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   // a clear discards any tick in the same cycle; the expiring tick restarts the count
   always_comb begin
      frame_expire = !clr && tick_in && (tick_cnt_q == TICK_LAST);
      tick_cnt_d   = (clr || frame_expire) ? '0 : tick_in ? tick_cnt_q + TICK_W'(1) : tick_cnt_q;
   end
   // tick counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick_cnt_q <= '0;
      else        tick_cnt_q <= tick_cnt_d;
   end
endmodule

// File: rtl/sc_transition_sequencer.sv
// sc_transition_sequencer: steps the frame ROM select through frames 0..LAST_FRAME for REPEAT passes;
// define TRANSITION_LOOP_EN to loop forever with a done pulse at every wrap
module sc_transition_sequencer
   import transition_pkg::*;
#(
   parameter int FRAME_TICKS = 4,
   parameter int REPEAT      = 1,
   parameter int LAST_FRAME  = 6
) (
   input  logic               sc_transition_sequencer_CLOCK_50,
   input  logic               sc_transition_sequencer_RESET_InLow,
   input  logic               sc_transition_sequencer_start_InLow,
   input  logic               sc_transition_sequencer_abort_InLow,
   input  logic               sc_transition_sequencer_tick_in,
   output logic [FRAME_W-1:0] sc_transition_sequencer_ctrl_out,
   output logic               sc_transition_sequencer_busy_out,
   output logic               sc_transition_sequencer_done_out
);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(LAST_FRAME);
   localparam logic [PASS_W-1:0]  PASS_LAST  = PASS_W'(REPEAT - 1);
   logic               clk, rst_n, start_n, abort_n;
   logic               frame_expire, wrap;
   state_e             state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d, ctrl_q, ctrl_d;
   logic [PASS_W-1:0]  pass_q, pass_d;
   logic               busy_q, busy_d, done_q, done_d;
   assign clk     = sc_transition_sequencer_CLOCK_50;
   assign rst_n   = sc_transition_sequencer_RESET_InLow;
   assign start_n = sc_transition_sequencer_start_InLow;
   assign abort_n = sc_transition_sequencer_abort_InLow;
   sc_transition_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (state_q != PLAY || !abort_n),
      .tick_in      (sc_transition_sequencer_tick_in),
      .frame_expire (frame_expire)
   );
   // next state and frame/pass progression; outputs are derived from the next state so they register cleanly
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      pass_d  = pass_q;
      wrap    = 1'b0;
      case (state_q)
         IDLE: if (!start_n && abort_n) begin
            state_d = PLAY;
            frame_d = '0;
            pass_d  = '0;
         end
         PLAY: if (!abort_n) state_d = IDLE;
         else if (frame_expire) begin
            if (frame_q < FRAME_LAST) frame_d = frame_q + FRAME_W'(1);
            else begin
`ifdef TRANSITION_LOOP_EN
               frame_d = '0;
               wrap    = 1'b1;
`else
               if (pass_q < PASS_LAST) begin
                  frame_d = '0;
                  pass_d  = pass_q + PASS_W'(1);
               end else state_d = DONE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      ctrl_d = (state_d == PLAY) ? frame_d : CTRL_BLANK;
      busy_d = (state_d == PLAY);
      done_d = (state_d == DONE) || wrap;
   end
   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         frame_q <= '0;
         pass_q  <= '0;
         ctrl_q  <= CTRL_BLANK;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         pass_q  <= pass_d;
         ctrl_q  <= ctrl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign sc_transition_sequencer_ctrl_out = ctrl_q;
   assign sc_transition_sequencer_busy_out = busy_q;
   assign sc_transition_sequencer_done_out = done_q;
endmodule

// File: tb/tb_sc_transition_sequencer.sv
// tb_sc_transition_sequencer: two sequencer instances (A and B) checked against a tick-position model plus directed literals
module tb_sc_transition_sequencer;
`ifdef TRANSITION_LOOP_EN
   localparam int FT_A = 1;
`else
   localparam int FT_A = 2;
`endif
   localparam int RP_A = 1;
   localparam int FT_B = 3;
   localparam int RP_B = 2;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       st_n[2], ab_n[2], tk[2];
   logic [2:0] ctl[2];
   logic       bsy[2], dn[2];
   int         checks = 0;
   int         errors = 0;
   int         n, n0, d;
   logic [2:0] cap[$];
   logic [2:0] rc[41];
   logic       rb[41], rd[41];
   typedef struct {int mode; int pos; bit wrap;} mdl_t;
   mdl_t       m[2];
   mdl_t       mz = '{mode: 0, pos: 0, wrap: 1'b0};

   initial forever #5 clk = ~clk;

   sc_transition_sequencer #(.FRAME_TICKS(FT_A), .REPEAT(RP_A), .LAST_FRAME(6)) dut_a (
      .sc_transition_sequencer_CLOCK_50    (clk),
      .sc_transition_sequencer_RESET_InLow (rst_n),
      .sc_transition_sequencer_start_InLow (st_n[0]),
      .sc_transition_sequencer_abort_InLow (ab_n[0]),
      .sc_transition_sequencer_tick_in     (tk[0]),
      .sc_transition_sequencer_ctrl_out    (ctl[0]),
      .sc_transition_sequencer_busy_out    (bsy[0]),
      .sc_transition_sequencer_done_out    (dn[0])
   );
   sc_transition_sequencer #(.FRAME_TICKS(FT_B), .REPEAT(RP_B), .LAST_FRAME(6)) dut_b (
      .sc_transition_sequencer_CLOCK_50    (clk),
      .sc_transition_sequencer_RESET_InLow (rst_n),
      .sc_transition_sequencer_start_InLow (st_n[1]),
      .sc_transition_sequencer_abort_InLow (ab_n[1]),
      .sc_transition_sequencer_tick_in     (tk[1]),
      .sc_transition_sequencer_ctrl_out    (ctl[1]),
      .sc_transition_sequencer_busy_out    (bsy[1]),
      .sc_transition_sequencer_done_out    (dn[1])
   );

   // model: mode 0 idle, 1 play, 2 done; pos counts ticks consumed since start
   function automatic mdl_t step(mdl_t s, int ft, int rp, logic st, logic ab, logic t);
      mdl_t r = s;
      r.wrap = 1'b0;
      if (s.mode == 0) begin
         if (!st && ab) begin r.mode = 1; r.pos = 0; end
      end else if (s.mode == 1) begin
         if (!ab) r.mode = 0;
         else if (t) begin
            r.pos = s.pos + 1;
`ifdef TRANSITION_LOOP_EN
            if (r.pos % (7 * ft) == 0) r.wrap = 1'b1;
`else
            if (r.pos == 7 * ft * rp) r.mode = 2;
`endif
         end
      end else r.mode = 0;
      return r;
   endfunction

   function automatic logic [2:0] ex_ctrl(mdl_t s, int ft);
      return (s.mode == 1) ? 3'((s.pos / ft) % 7) : 3'd7;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < 2; i++) m[i] <= mz;
      else for (int i = 0; i < 2; i++)
         m[i] <= step(m[i], i ? FT_B : FT_A, i ? RP_B : RP_A, st_n[i], ab_n[i], tk[i]);
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // every-cycle comparison of both instances against the model
   initial forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("model ctrl[%0d]", i), 8'(ctl[i]), 8'(ex_ctrl(m[i], i ? FT_B : FT_A)));
         chk($sformatf("model busy[%0d]", i), 8'(bsy[i]), 8'(m[i].mode == 1));
         chk($sformatf("model done[%0d]", i), 8'(dn[i]), 8'(m[i].mode == 2 || m[i].wrap));
      end
   end

   // play while busy, ticking on every per-th cycle; captures ctrl per busy cycle
   task automatic play(input int i, input int per, input int lim, output int cnt);
      cap.delete();
      cnt = 0;
      while (bsy[i] && cnt < lim) begin
         cap.push_back(ctl[i]);
         tk[i] = (cnt % per == per - 1);
         @(negedge clk);
         cnt++;
      end
      tk[i] = 1'b0;
      chk("play bounded", 8'(cnt < lim), 8'd1);
   endtask

   task automatic start_pulse(input int i);
      st_n[i] = 1'b0;
      @(negedge clk);
      st_n[i] = 1'b1;
   endtask

   task automatic wait_frame(input int i, input logic [2:0] f);
      int k = 0;
      while (ctl[i] != f && k < 60) begin @(negedge clk); k++; end
      chk("reach frame", 8'(ctl[i]), 8'(f));
   endtask

   initial begin
      st_n = '{1'b1, 1'b1};
      ab_n = '{1'b1, 1'b1};
      tk   = '{1'b0, 1'b0};
      repeat (3) @(negedge clk);
      chk("reset ctrl", 8'(ctl[0]), 8'd7);
      chk("reset busy", 8'(bsy[0]), 8'd0);
      chk("reset done", 8'(dn[1]), 8'd0);
      rst_n = 1'b1;
      @(negedge clk);
`ifndef TRANSITION_LOOP_EN
      // single pass, tick every cycle including the start cycle
      tk[0] = 1'b1;
      start_pulse(0);
      chk("start latency ctrl", 8'(ctl[0]), 8'd0);
      chk("start busy", 8'(bsy[0]), 8'd1);
      play(0, 1, 100, n);
      chk("pass length", 8'(n), 8'd14);
      for (int k = 0; k < cap.size(); k++) chk("frame seq", 8'(cap[k]), 8'(k / 2));
      chk("done pulse", 8'(dn[0]), 8'd1);
      chk("done ctrl", 8'(ctl[0]), 8'd7);
      chk("done busy", 8'(bsy[0]), 8'd0);
      @(negedge clk);
      chk("after done", 8'(dn[0]), 8'd0);
      chk("after done ctrl", 8'(ctl[0]), 8'd7);
      // two passes, tick every 4th cycle on B
      start_pulse(1);
      play(1, 4, 400, n);
      chk("two pass length", 8'(n / 2), 8'd84);
      for (int k = 0; k < cap.size(); k += 11) chk("held frame", 8'(cap[k]), 8'((k / 12) % 7));
      chk("b done", 8'(dn[1]), 8'd1);
      // reset mid-run at frame 3
      tk[0] = 1'b1;
      start_pulse(0);
      wait_frame(0, 3'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("rst ctrl", 8'(ctl[0]), 8'd7);
      chk("rst busy", 8'(bsy[0]), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d = 0;
      repeat (20) begin @(negedge clk); d |= int'(dn[0]); end
      chk("no done after reset", 8'(d), 8'd0);
      // abort at frame 4 with a tick in the same cycle, then start+abort together
      start_pulse(0);
      wait_frame(0, 3'd4);
      ab_n[0] = 1'b0;
      @(negedge clk);
      chk("abort ctrl", 8'(ctl[0]), 8'd7);
      chk("abort busy", 8'(bsy[0]), 8'd0);
      chk("abort done", 8'(dn[0]), 8'd0);
      st_n[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort wins ctrl", 8'(ctl[0]), 8'd7);
      chk("abort wins busy", 8'(bsy[0]), 8'd0);
      st_n[0] = 1'b1;
      ab_n[0] = 1'b1;
      @(negedge clk);
      // start pulsed mid-play is ignored
      start_pulse(0);
      n0 = 0;
      while (ctl[0] != 3'd2 && n0 < 60) begin @(negedge clk); n0++; end
      start_pulse(0);
      chk("start in play ctrl", 8'(ctl[0]), 8'd2);
      play(0, 1, 100, n);
      chk("unaffected length", 8'(n0 + 1 + n), 8'd14);
      chk("unaffected done", 8'(dn[0]), 8'd1);
      @(negedge clk);
      // start held low across a full run
      tk[0] = 1'b1;
      st_n[0] = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         rc[k] = ctl[0];
         rb[k] = bsy[0];
         rd[k] = dn[0];
      end
      st_n[0] = 1'b1;
      chk("held first ctrl", 8'(rc[1]), 8'd0);
      chk("held done", 8'(rd[15]), 8'd1);
      chk("held blank ctrl", 8'(rc[16]), 8'd7);
      chk("held blank busy", 8'(rb[16]), 8'd0);
      chk("held blank done", 8'(rd[16]), 8'd0);
      chk("restart ctrl", 8'(rc[17]), 8'd0);
      chk("restart busy", 8'(rb[17]), 8'd1);
      ab_n[0] = 1'b0;
      @(negedge clk);
      ab_n[0] = 1'b1;
      tk[0] = 1'b0;
`else
      // looping with one tick per frame
      tk[0] = 1'b1;
      st_n[0] = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         st_n[0] = 1'b1;
         rc[k] = ctl[0];
         rb[k] = bsy[0];
         rd[k] = dn[0];
      end
      for (int k = 1; k <= 30; k++) begin
         chk("loop ctrl", 8'(rc[k]), 8'((k - 1) % 7));
         chk("loop busy", 8'(rb[k]), 8'd1);
         chk("loop done", 8'(rd[k]), 8'(k > 1 && (k - 1) % 7 == 0));
      end
      ab_n[0] = 1'b0;
      @(negedge clk);
      chk("loop abort ctrl", 8'(ctl[0]), 8'd7);
      chk("loop abort busy", 8'(bsy[0]), 8'd0);
      chk("loop abort done", 8'(dn[0]), 8'd0);
      ab_n[0] = 1'b1;
      tk[0] = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
